pipe_stage_ctrl: RTL and testbench

//  Sequencing controller for the 5-stage pipeline (IF, ID, EX, MA, RW).
//  - Drives the load-enable and bubble (flush) controls of the PC and of the IF_ID, ID_EX, EX_MA and MA_RW stage registers.
//  - Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits.
//  - Sits beside the datapath and snoops the instruction words held in the ID, EX and MA stages.

---
 rtl/pipe_stage_ctrl_pkg.sv | 22 ++
 rtl/pipe_stage_ctrl_if.sv | 41 ++++
 rtl/pipe_stage_ctrl_hazard.sv | 24 ++
 rtl/pipe_stage_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_stage_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_ctrl_pkg.sv
// Shared constants, field positions and FSM state type for the pipeline sequencing controller.
// Optional build macro consumed by the users of this package: PIPE_PERF_CNT_EN.
package pipe_pkg;
    localparam logic [4:0]  OP_LD    = 5'h04;
    localparam logic [4:0]  OP_ST    = 5'h05;
    localparam logic [31:0] NOP_INST = 32'd0;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS1_MSB = 21;
    localparam int RS1_LSB = 17;
    localparam int RS2_MSB = 16;
    localparam int RS2_LSB = 12;

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} pipe_state_t;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == OP_LD) || (op == OP_ST);
    endfunction
endpackage

// File: rtl/pipe_stage_ctrl_if.sv
// Snoop/control bundle between the datapath (master) and the stage controller (slave).
// Perf counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipe_stage_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0] id_inst;
    logic [31:0] ex_inst;
    logic [31:0] ma_inst;
    logic        ex_br_taken;
    logic        dmem_busy;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_ma_en;
    logic        ma_rw_en;
    logic        if_id_flush;
    logic        id_ex_flush;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

    modport master (
        output id_inst, ex_inst, ma_inst, ex_br_taken, dmem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_ma_en, ma_rw_en, if_id_flush, id_ex_flush
`ifdef PIPE_PERF_CNT_EN
        , input stall_cycles, flush_cycles
`endif
    );

    modport slave (
        input  id_inst, ex_inst, ma_inst, ex_br_taken, dmem_busy,
        output pc_en, if_id_en, id_ex_en, ex_ma_en, ma_rw_en, if_id_flush, id_ex_flush
`ifdef PIPE_PERF_CNT_EN
        , output stall_cycles, flush_cycles
`endif
    );
endinterface

// File: rtl/pipe_stage_ctrl_hazard.sv
// Load-use detector: a load in EX whose destination feeds either source of the ID instruction.
module pipe_hazard_cmp
    import pipe_pkg::*;
(
    input  logic [31:0] i_id_inst,
    input  logic [31:0] i_ex_inst,
    output logic        o_load_use
);
    logic [4:0] w_ex_opc;
    logic [4:0] w_ex_rd;
    logic [4:0] w_id_rs1;
    logic [4:0] w_id_rs2;
    logic       w_unused;

    assign w_ex_opc = i_ex_inst[OPC_MSB:OPC_LSB];
    assign w_ex_rd  = i_ex_inst[RD_MSB:RD_LSB];
    assign w_id_rs1 = i_id_inst[RS1_MSB:RS1_LSB];
    assign w_id_rs2 = i_id_inst[RS2_MSB:RS2_LSB];
    assign w_unused = ^{i_id_inst[OPC_MSB:RD_LSB], i_id_inst[RS2_LSB-1:0], i_ex_inst[RS1_MSB:0]};

    // r0 is hardwired, so a load targeting it never forces a bubble
    assign o_load_use = (w_ex_opc == OP_LD) && (w_ex_rd != 5'd0) &&
                        ((w_ex_rd == w_id_rs1) || (w_ex_rd == w_id_rs2));
endmodule

// File: rtl/pipe_stage_ctrl.sv
// 5-stage pipeline sequencing controller: memory freeze > branch flush > load-use stall > run.
// Define PIPE_PERF_CNT_EN to add saturating stall/flush cycle counters.
module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter int BR_FLUSH_CYC = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_stage_ctrl_if.slave  bus
);
    localparam logic [1:0] BR_RELOAD = 2'(BR_FLUSH_CYC - 1);

    pipe_state_t r_state, w_nstate;
    logic [1:0]  r_cnt, w_ncnt;
    logic        r_pend, w_npend;
    logic        w_load_use, w_freeze, w_new_br, w_owed, w_unused_ma;
    logic        w_pc_en, w_if_id_en, w_id_ex_en, w_ex_ma_en, w_ma_rw_en;
    logic        w_if_id_flush, w_id_ex_flush;

    pipe_hazard_cmp u_hazard (
        .i_id_inst  (bus.id_inst),
        .i_ex_inst  (bus.ex_inst),
        .o_load_use (w_load_use)
    );

    assign w_unused_ma = ^bus.ma_inst[RD_MSB:0];
    assign w_freeze    = is_mem_op(bus.ma_inst[OPC_MSB:OPC_LSB]) && bus.dmem_busy;
    assign w_new_br    = bus.ex_br_taken || r_pend;
    // r_cnt counts flush cycles still owed after the current one; it survives a freeze
    assign w_owed      = (r_state != RUN) && (r_cnt != 2'd0);

    always_comb begin
        w_pc_en       = 1'b1;
        w_if_id_en    = 1'b1;
        w_id_ex_en    = 1'b1;
        w_ex_ma_en    = 1'b1;
        w_ma_rw_en    = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_nstate      = r_state;
        w_ncnt        = r_cnt;
        w_npend       = r_pend;
        if (!rst_n) begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_ma_en, w_ma_rw_en} = 5'b0;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_freeze) begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_ma_en, w_ma_rw_en} = 5'b0;
            w_npend  = r_pend || bus.ex_br_taken;
            w_nstate = MEM_WAIT;
        end else if (w_new_br || w_owed) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_ncnt        = w_new_br ? BR_RELOAD : r_cnt - 2'd1;
            w_npend       = 1'b0;
            w_nstate      = (w_ncnt != 2'd0) ? FLUSH : RUN;
        end else begin
            w_npend  = 1'b0;
            w_nstate = RUN;
            if (w_load_use) begin
                w_pc_en       = 1'b0;
                w_if_id_en    = 1'b0;
                w_id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
            r_pend  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_cnt   <= w_ncnt;
            r_pend  <= w_npend;
        end
    end

    assign bus.pc_en       = w_pc_en;
    assign bus.if_id_en    = w_if_id_en;
    assign bus.id_ex_en    = w_id_ex_en;
    assign bus.ex_ma_en    = w_ex_ma_en;
    assign bus.ma_rw_en    = w_ma_rw_en;
    assign bus.if_id_flush = w_if_id_flush;
    assign bus.id_ex_flush = w_id_ex_flush;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cycles, r_flush_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (!w_pc_en && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + 1'b1;
            if (w_if_id_flush && (r_flush_cycles != {CNT_W{1'b1}}))
                r_flush_cycles <= r_flush_cycles + 1'b1;
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_cycles = r_flush_cycles;
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Bench for pipe_stage_ctrl: directed steps then random traffic on BR_FLUSH_CYC=2 and =1 instances.
// Counter checks are active when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_ctrl;
    import pipe_pkg::*;

    localparam logic [4:0] OP_ADD = 5'h01;
    // {pc, if_id, id_ex, ex_ma, ma_rw, if_id_flush, id_ex_flush}
    localparam logic [6:0] NRM = 7'b1111100;
    localparam logic [6:0] STL = 7'b0011101;
    localparam logic [6:0] FLS = 7'b1111111;
    localparam logic [6:0] FRZ = 7'b0000000;
    localparam logic [6:0] RST = 7'b0000011;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipe_stage_ctrl_if ifa ();
    pipe_stage_ctrl_if ifb ();

    assign ifb.id_inst     = ifa.id_inst;
    assign ifb.ex_inst     = ifa.ex_inst;
    assign ifb.ma_inst     = ifa.ma_inst;
    assign ifb.ex_br_taken = ifa.ex_br_taken;
    assign ifb.dmem_busy   = ifa.dmem_busy;

    pipe_stage_ctrl #(.BR_FLUSH_CYC(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    pipe_stage_ctrl #(.BR_FLUSH_CYC(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    logic [6:0] oa, ob;
    assign oa = {ifa.pc_en, ifa.if_id_en, ifa.id_ex_en, ifa.ex_ma_en, ifa.ma_rw_en, ifa.if_id_flush, ifa.id_ex_flush};
    assign ob = {ifb.pc_en, ifb.if_id_en, ifb.id_ex_en, ifb.ex_ma_en, ifb.ma_rw_en, ifb.if_id_flush, ifb.id_ex_flush};

    int  n_chk = 0, n_pass = 0;
    int  owA = 0, owB = 0, nowA, nowB;
    bit  pdA = 0, pdB = 0, npdA, npdB;
    longint stc = 0, flc = 0;
    logic [6:0] eA, eB;

    function automatic logic [31:0] mk(input logic [4:0] op, rd, rs1, rs2);
        return {op, rd, rs1, rs2, 12'd0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, o, e);
    endtask

    // Rules: a busy LD/ST in MA freezes and banks any branch; a branch flushes for
    // br_cyc cycles in total; otherwise a load-use bubble; otherwise run.
    function automatic void model(input int br_cyc, input logic rst, input logic [31:0] id, ex, ma,
                                  input logic br, busy, input int ow, input bit pd,
                                  output logic [6:0] o, output int now, output bit npd);
        logic [4:0] mop, eop, erd;
        bit mem, lu;
        mop = ma[31:27]; eop = ex[31:27]; erd = ex[26:22];
        mem = (mop == OP_LD || mop == OP_ST) && busy;
        lu  = (eop == OP_LD) && (erd != 0) && (erd == id[21:17] || erd == id[16:12]);
        now = ow; npd = 1'b0;
        if (!rst) begin o = RST; now = 0; end
        else if (mem) begin o = FRZ; npd = pd | br; end
        else if (br || pd) begin o = FLS; now = br_cyc - 1; end
        else if (ow > 0) begin o = FLS; now = ow - 1; end
        else if (lu) o = STL;
        else o = NRM;
    endfunction

    task automatic step(input string tag, input logic [31:0] id, ex, ma, input logic br, busy,
                        input bit dir, input logic [6:0] xa, xb);
        ifa.id_inst = id; ifa.ex_inst = ex; ifa.ma_inst = ma;
        ifa.ex_br_taken = br; ifa.dmem_busy = busy;
        #1;
        model(2, rst_n, id, ex, ma, br, busy, owA, pdA, eA, nowA, npdA);
        model(1, rst_n, id, ex, ma, br, busy, owB, pdB, eB, nowB, npdB);
        if (dir) begin
            chk({tag, "/br2"}, {25'd0, oa}, {25'd0, xa});
            chk({tag, "/br1"}, {25'd0, ob}, {25'd0, xb});
        end else begin
            chk({tag, "/br2"}, {25'd0, oa}, {25'd0, eA});
            chk({tag, "/br1"}, {25'd0, ob}, {25'd0, eB});
        end
`ifdef PIPE_PERF_CNT_EN
        chk({tag, "/stall_cnt"}, ifa.stall_cycles, stc[31:0]);
        chk({tag, "/flush_cnt"}, ifa.flush_cycles, flc[31:0]);
`endif
        @(posedge clk);
        owA = nowA; pdA = npdA; owB = nowB; pdB = npdB;
        if (rst_n) begin
            if (!eA[6]) stc++;
            if (eA[1]) flc++;
        end else begin
            stc = 0; flc = 0;
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [4:0] op;
        case ($urandom_range(0, 3))
            0: op = 5'h00;
            1: op = OP_LD;
            2: op = OP_ST;
            default: op = OP_ADD;
        endcase
        return mk(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    endfunction

    initial begin
        logic [31:0] nop, ld5, use5, ld0, use0, st, add;
        nop  = NOP_INST;
        ld5  = mk(OP_LD, 5'd5, 5'd1, 5'd0);
        use5 = mk(OP_ADD, 5'd7, 5'd5, 5'd2);
        ld0  = mk(OP_LD, 5'd0, 5'd1, 5'd0);
        use0 = mk(OP_ADD, 5'd7, 5'd0, 5'd2);
        st   = mk(OP_ST, 5'd0, 5'd3, 5'd4);
        add  = mk(OP_ADD, 5'd1, 5'd2, 5'd3);

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) step("reset", nop, nop, nop, 0, 0, 1, RST, RST);
        rst_n = 1'b1;
        step("run0", nop, nop, nop, 0, 0, 1, NRM, NRM);

        step("lu_stall", use5, ld5, nop, 0, 0, 1, STL, STL);
        step("lu_after", use5, nop, ld5, 0, 0, 1, NRM, NRM);
        step("lu_r0", use0, ld0, nop, 0, 0, 1, NRM, NRM);

        step("br_c0", nop, nop, nop, 1, 0, 1, FLS, FLS);
        step("br_c1", nop, nop, nop, 0, 0, 1, FLS, NRM);
        step("br_c2", nop, nop, nop, 0, 0, 1, NRM, NRM);

        for (int i = 0; i < 4; i++) step("mem_frz", nop, nop, st, 0, 1, 1, FRZ, FRZ);
        step("mem_rel", nop, nop, st, 0, 0, 1, NRM, NRM);
        step("mem_add", nop, nop, add, 0, 1, 1, NRM, NRM);

        step("col_brlu", use5, ld5, nop, 1, 0, 1, FLS, FLS);
        step("col_brlu1", nop, nop, nop, 0, 0, 1, FLS, NRM);
        step("col_frz0", nop, nop, st, 1, 1, 1, FRZ, FRZ);
        step("col_frz1", nop, nop, st, 0, 1, 1, FRZ, FRZ);
        step("col_rel", nop, nop, st, 0, 0, 1, FLS, FLS);
        step("col_rel1", nop, nop, nop, 0, 0, 1, FLS, NRM);
        step("col_end", nop, nop, nop, 0, 0, 1, NRM, NRM);

        step("ar_br", nop, nop, nop, 1, 0, 1, FLS, FLS);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_imm/br2", {25'd0, oa}, {25'd0, RST});
        chk("ar_imm/br1", {25'd0, ob}, {25'd0, RST});
`ifdef PIPE_PERF_CNT_EN
        chk("ar_imm/stall_cnt", ifa.stall_cycles, 32'd0);
        chk("ar_imm/flush_cnt", ifa.flush_cycles, 32'd0);
`endif
        owA = 0; owB = 0; pdA = 0; pdB = 0; stc = 0; flc = 0;
        step("ar_hold", nop, nop, nop, 0, 0, 1, RST, RST);
        rst_n = 1'b1;
        step("ar_run", nop, nop, nop, 0, 0, 1, NRM, NRM);

        for (int i = 0; i < 400; i++)
            step("rand", rnd_inst(), rnd_inst(), rnd_inst(), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0), 0, NRM, NRM);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
